// File: rtl/ram_sync_pkg.sv
// Shared op encodings and FSM states for the read/write/increment-and-store RAM block.
// Included ahead of ram_sync_array and ram_sync_rmw.
package ram_sync_pkg;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ISZ = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_INC_WR
  } state_e;

endpackage

// File: rtl/ram_sync_array.sv
// Plain single-clock RAM: one write port, one read port registered on clk.
// Read data appears the cycle after the address is sampled; no backpressure.
module ram_sync_array #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdat,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdat
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  always_comb begin
    rd_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdat;
    end
    rd_q <= rd_d;
  end

  assign rdat = rd_q;

endmodule

// File: rtl/ram_sync_rmw.sv
// RAM with read (1-cycle), posted write (ack next cycle, back-to-back) and ISZ (2-cycle) ops;
// zero-fills on reset, ready low while busy. Define RAM_SYNC_PARITY_EN for a per-word even-parity bit.
module ram_sync_rmw
  import ram_sync_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              par_flip,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              zero,
  output logic              par_err
);

`ifdef RAM_SYNC_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               isz_q, isz_d;
  logic               wr_ack_q, wr_ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               zero_q, zero_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wword;
  logic               mem_wflip;
  logic [MEM_W-1:0]   mem_wdat;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [MEM_W-1:0]   mem_rdat;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  rd_inc;
  logic               rd_ack;

  assign rd_word = mem_rdat[DATA_W-1:0];
  assign rd_inc  = rd_word + 1'b1;

  // The array samples its read address on the accept edge, so IDLE looks at the live port.
  assign mem_raddr = (state_q == ST_IDLE) ? addr : addr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    isz_d     = isz_q;
    wr_ack_d  = 1'b0;
    rdata_d   = rdata_q;
    zero_d    = zero_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wword = '0;
    mem_wflip = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req) begin
          addr_d = addr;
          if (op == OP_WR) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wword = wdata;
            mem_wflip = par_flip;
            wr_ack_d  = 1'b1;
            rdata_d   = wdata;
            zero_d    = 1'b0;
          end else begin
            isz_d   = (op == OP_ISZ);
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        // ISZ parks the incremented word in rdata_q; INC_WR writes it back from there.
        if (isz_q) begin
          rdata_d = rd_inc;
          zero_d  = (rd_inc == '0);
          state_d = ST_INC_WR;
        end else begin
          rdata_d = rd_word;
          zero_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_INC_WR: begin
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wword = rdata_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      addr_q   <= '0;
      isz_q    <= 1'b0;
      wr_ack_q <= 1'b0;
      rdata_q  <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      isz_q    <= isz_d;
      wr_ack_q <= wr_ack_d;
      rdata_q  <= rdata_d;
      zero_q   <= zero_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign rd_ack = (state_q == ST_RD) && !isz_q;
  assign ack    = rd_ack || (state_q == ST_INC_WR) || wr_ack_q;
  assign rdata  = rd_ack ? rd_word : rdata_q;
  assign zero   = rd_ack ? 1'b0 : zero_q;

`ifdef RAM_SYNC_PARITY_EN
  logic par_bad;
  logic par_err_q, par_err_d;

  assign mem_wdat = {(^mem_wword) ^ mem_wflip, mem_wword};
  assign par_bad  = (state_q == ST_RD) && ((^rd_word) != mem_rdat[DATA_W]);

  always_comb begin
    par_err_d = par_err_q | par_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  // A plain read acks in RD itself, so the flag is forwarded before it registers.
  assign par_err = par_err_q | (rd_ack & par_bad);
`else
  logic unused_par_flip;

  assign mem_wdat        = mem_wword;
  assign par_err         = 1'b0;
  assign unused_par_flip = mem_wflip;
`endif

  ram_sync_array #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdat  (mem_wdat),
    .raddr (mem_raddr),
    .rdat  (mem_rdat)
  );

endmodule
